ex_muldiv: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit beside the single-cycle EX ALU; the next-generation

---
 rtl/ex_muldiv.sv | 216 +++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Multi-cycle RV32M multiply/divide unit beside the EX ALU.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic [REG_AW-1:0] i_wd,
    input  logic              i_wreg,
    input  logic              i_flush,
    output logic              o_stall_req,
    output logic              o_busy,
    output logic              o_done,
    output logic [XLEN-1:0]   o_result,
    output logic [REG_AW-1:0] o_wd,
    output logic              o_wreg
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int MW = $clog2(MUL_LAT + 1) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic [CW-1:0]     r_cnt;
    logic [MW-1:0]     r_mcnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [REG_AW-1:0] r_wd;
    logic              r_wreg;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [REG_AW-1:0] r_wd_o;
    logic              r_wreg_o;

    logic              w_idle;
    logic              w_accept;
    logic              w_sgn;
    logic              w_zero;
    logic              w_ovf;
    logic              w_corner;
    logic [XLEN-1:0]   w_corner_res;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;

    logic [2:0]        w_mop;
    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_src_b;
    logic              w_sa;
    logic              w_sb;
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_quo_nx;
    logic [XLEN-1:0]   w_div_res;

    logic [1:0]        w_state_nx;
    logic [XLEN-1:0]   w_res_nx;
    logic              w_done_nx;

    assign w_idle   = (r_state == c_IDLE);
    assign w_accept = w_idle & i_start & ~i_flush;

    // Corner cases are resolved straight from the ID/EX operands at accept.
    assign w_sgn        = ~i_op[0];
    assign w_zero       = (i_rs2 == '0);
    assign w_ovf        = w_sgn & (i_rs1 == c_MIN) & (i_rs2 == '1);
    assign w_corner     = i_op[2] & (w_zero | w_ovf);
    assign w_corner_res = w_zero ? (i_op[1] ? i_rs1 : '1)
                                 : (i_op[1] ? '0    : i_rs1);
    assign w_abs1 = (w_sgn & i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
    assign w_abs2 = (w_sgn & i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;

    // With MUL_LAT=1 the product is taken directly from the inputs in IDLE.
    assign w_mop     = w_idle ? i_op  : r_op;
    assign w_src_a   = w_idle ? i_rs1 : r_a;
    assign w_src_b   = w_idle ? i_rs2 : r_b;
    assign w_sa      = (w_mop == 3'd1) | (w_mop == 3'd2);
    assign w_sb      = (w_mop == 3'd1);
    assign w_ma      = {{XLEN{w_sa & w_src_a[XLEN-1]}}, w_src_a};
    assign w_mb      = {{XLEN{w_sb & w_src_b[XLEN-1]}}, w_src_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (w_mop[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // One restoring step; the final step's result feeds the output register directly.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[XLEN];
    assign w_rem_nx  = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nx  = {r_quo[XLEN-2:0], w_qbit};
    assign w_div_res = r_op[1] ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                               : (r_neg_q ? -w_quo_nx : w_quo_nx);

    always_comb begin
        w_state_nx = r_state;
        w_res_nx   = '0;
        case (r_state)
            c_IDLE: begin
                if (i_op[2]) begin
                    w_res_nx = w_corner_res;
                end else begin
                    w_res_nx = w_mul_res;
                end
                if (w_accept) begin
                    if (i_op[2]) begin
                        w_state_nx = w_corner ? c_DONE : c_DIV;
                    end else begin
                        w_state_nx = (MUL_LAT == 1) ? c_DONE : c_MUL;
                    end
                end
            end
            c_MUL: begin
                w_res_nx = w_mul_res;
                if (32'(r_mcnt) == 32'(MUL_LAT - 2)) begin
                    w_state_nx = c_DONE;
                end
            end
            c_DIV: begin
                w_res_nx = w_div_res;
                if (r_cnt == CW'(XLEN - 1)) begin
                    w_state_nx = c_DONE;
                end
            end
            default: w_state_nx = c_IDLE;
        endcase
        if (i_flush) begin
            w_state_nx = c_IDLE;
        end
    end

    assign w_done_nx = (w_state_nx == c_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_mcnt   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_wd     <= '0;
            r_wreg   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_wd_o   <= '0;
            r_wreg_o <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_done   <= w_done_nx;
            r_result <= w_done_nx ? w_res_nx : '0;
            r_wd_o   <= w_done_nx ? (w_idle ? i_wd : r_wd) : '0;
            r_wreg_o <= w_done_nx & (w_idle ? i_wreg : r_wreg);
            if (w_accept) begin
                r_op    <= i_op;
                r_a     <= i_rs1;
                r_b     <= i_rs2;
                r_wd    <= i_wd;
                r_wreg  <= i_wreg;
                r_quo   <= w_abs1;
                r_rem   <= '0;
                r_dvs   <= w_abs2;
                r_cnt   <= '0;
                r_mcnt  <= '0;
                r_neg_q <= w_sgn & (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
                r_neg_r <= w_sgn & i_rs1[XLEN-1];
            end else if (r_state == c_DIV) begin
                r_quo <= w_quo_nx;
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == c_MUL) begin
                r_mcnt <= r_mcnt + 1'b1;
            end
        end
    end

    assign o_stall_req = (w_idle & i_start & ~i_flush) | (r_state == c_MUL) | (r_state == c_DIV);
    assign o_busy      = ~w_idle;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_wd        = r_wd_o;
    assign o_wreg      = r_wreg_o;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Directed vector bench for ex_muldiv (XLEN=32, MUL_LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int REG_AW  = 5;
    localparam int NV      = 22;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [2:0]        i_op;
    logic [XLEN-1:0]   i_rs1;
    logic [XLEN-1:0]   i_rs2;
    logic [REG_AW-1:0] i_wd;
    logic              i_wreg;
    logic              i_flush;
    logic              o_stall_req;
    logic              o_busy;
    logic              o_done;
    logic [XLEN-1:0]   o_result;
    logic [REG_AW-1:0] o_wd;
    logic              o_wreg;

    ex_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .REG_AW(REG_AW)) u_dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_rs1(i_rs1),
        .i_rs2(i_rs2), .i_wd(i_wd), .i_wreg(i_wreg), .i_flush(i_flush),
        .o_stall_req(o_stall_req), .o_busy(o_busy), .o_done(o_done),
        .o_result(o_result), .o_wd(o_wd), .o_wreg(o_wreg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tv [NV];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    always @(negedge clk) if (o_done) n_done++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the unit idle.
    task automatic run_op(input int idx, input vec_t v);
        int  cyc;
        bit  seen;
        i_start = 1'b1;
        i_op    = v.op;
        i_rs1   = v.a;
        i_rs2   = v.b;
        i_wd    = idx[4:0];
        i_wreg  = idx[0];
        #1;
        chk($sformatf("v%0d stall_T", idx), {31'd0, o_stall_req}, 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            if (o_done) seen = 1'b1;
            else chk($sformatf("v%0d stall_busy", idx), {31'd0, o_stall_req}, 32'd1);
        end
        i_start = 1'b0;
        chk($sformatf("v%0d latency", idx), cyc, v.lat);
        chk($sformatf("v%0d result", idx), o_result, v.res);
        chk($sformatf("v%0d wd", idx), {27'd0, o_wd}, {27'd0, idx[4:0]});
        chk($sformatf("v%0d wreg", idx), {31'd0, o_wreg}, {31'd0, idx[0]});
        chk($sformatf("v%0d stall_done", idx), {31'd0, o_stall_req}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d done_clr", idx), {31'd0, o_done}, 32'd0);
        chk($sformatf("v%0d result_clr", idx), o_result, 32'd0);
        chk($sformatf("v%0d busy_clr", idx), {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int   base;
        vec_t mv;
        tv[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 2};
        tv[1]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 2};
        tv[2]  = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 2};
        tv[3]  = '{3'd3, 32'hFFFFFFFF,   32'd2,        32'h00000001, 2};
        tv[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
        tv[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
        tv[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       33};
        tv[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        33};
        tv[8]  = '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        tv[9]  = '{3'd6, 32'd5,          32'd0,        32'd5,        1};
        tv[10] = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        tv[11] = '{3'd7, 32'h12345678,   32'd0,        32'h12345678, 1};
        tv[12] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        tv[13] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        tv[14] = '{3'd5, 32'h80000000,   32'hFFFFFFFF, 32'd0,        33};
        tv[15] = '{3'd7, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33};
        tv[16] = '{3'd4, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        tv[17] = '{3'd6, 32'd7,          32'hFFFFFFFE, 32'd1,        33};
        tv[18] = '{3'd0, 32'h12345678,   32'h10,       32'h23456780, 2};
        tv[19] = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        2};
        tv[20] = '{3'd5, 32'hFFFFFFFF,   32'd3,        32'h55555555, 33};
        tv[21] = '{3'd6, 32'h80000000,   32'd3,        32'hFFFFFFFE, 33};

        rst = 1'b1; i_start = 1'b0; i_op = '0; i_rs1 = '0; i_rs2 = '0;
        i_wd = '0; i_wreg = 1'b0; i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", {31'd0, o_done}, 32'd0);
        chk("rst result", o_result, 32'd0);
        chk("rst busy", {31'd0, o_busy}, 32'd0);
        chk("rst stall", {31'd0, o_stall_req}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_op(i, tv[i]);

        // Flush ten cycles into a divide, then a multiply right behind it.
        base = n_done;
        i_start = 1'b1; i_op = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_wd = 5'd9; i_wreg = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        i_flush = 1'b1; i_start = 1'b0;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush busy", {31'd0, o_busy}, 32'd0);
        chk("flush done", {31'd0, o_done}, 32'd0);
        chk("flush wreg", {31'd0, o_wreg}, 32'd0);
        chk("flush no_done", n_done - base, 0);
        mv = '{3'd0, 32'd6, 32'd9, 32'd54, 2};
        run_op(3, mv);

        // Reset in the middle of a divide.
        i_start = 1'b1; i_op = 3'd5; i_rs1 = 32'd77; i_rs2 = 32'd5; i_wd = 5'd3; i_wreg = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; i_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid done", {31'd0, o_done}, 32'd0);
        chk("rstmid result", o_result, 32'd0);
        chk("rstmid busy", {31'd0, o_busy}, 32'd0);
        chk("rstmid stall", {31'd0, o_stall_req}, 32'd0);
        chk("rstmid wd", {27'd0, o_wd}, 32'd0);
        chk("rstmid wreg", {31'd0, o_wreg}, 32'd0);

        // start held high through DONE must not re-issue.
        base = n_done;
        i_start = 1'b1; i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd4; i_wd = 5'd1; i_wreg = 1'b1;
        repeat (MUL_LAT) begin @(posedge clk); #1; end
        chk("hold done", {31'd0, o_done}, 32'd1);
        chk("hold result", o_result, 32'd12);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("hold busy", {31'd0, o_busy}, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        chk("hold one_done", n_done - base, 1);

        // start together with flush in IDLE is not accepted.
        i_start = 1'b1; i_flush = 1'b1; i_op = 3'd4; i_rs1 = 32'd8; i_rs2 = 32'd2;
        #1;
        chk("flushidle stall", {31'd0, o_stall_req}, 32'd0);
        @(posedge clk); #1;
        i_start = 1'b0; i_flush = 1'b0;
        chk("flushidle busy", {31'd0, o_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
